// File: rtl/freq_pkg.sv
// Shared constants and FSM encoding for the DDS-style frequency generator.
package freq_pkg;
    localparam int NDIGITS = 8;
    localparam int FCLK_10 = 10_000_000;
    localparam int FCLK_50 = 50_000_000;
    localparam int ACC_W   = 27;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        APPLY   = 2'd2
    } state_t;
endpackage

// File: rtl/bcd_to_bin_acc.sv
// Serial BCD-to-binary converter: folds one decimal digit per accepted beat into shadow.
module bcd_to_bin_acc #(
    parameter int NDIGITS = freq_pkg::NDIGITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       accept,
    input  logic                       clr,
    input  logic [3:0]                 digit,
    output logic [freq_pkg::ACC_W-1:0] shadow,
    output logic                       bad,
    output logic                       last
);
    import freq_pkg::*;

    localparam int CNT_W = $clog2(NDIGITS + 1);

    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] times10;

    // x*10 = x*8 + x*2; overflow from non-decimal digits is harmless, bad flags it
    assign times10 = (shadow << 3) + (shadow << 1);
    assign last    = accept && (count == CNT_W'(NDIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            count  <= '0;
            bad    <= 1'b0;
        end else if (clr) begin
            shadow <= '0;
            count  <= '0;
            bad    <= 1'b0;
        end else if (accept) begin
            shadow <= times10 + ACC_W'(digit);
            count  <= count + 1'b1;
            bad    <= bad | (digit > 4'd9);
        end
    end
endmodule

// File: rtl/freq_gen.sv
// Setpoint-programmable square-wave generator: BCD setpoint collection, range check,
// and a phase accumulator that toggles sig_out on each modulus wrap.
module freq_gen #(
    parameter int NDIGITS = freq_pkg::NDIGITS,
    parameter int FCLK_50 = freq_pkg::FCLK_50,
    parameter int FCLK_10 = freq_pkg::FCLK_10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       n10_50,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    output logic       digit_ready,
    output logic       sig_out,
    output logic       active,
    output logic       err
);
    import freq_pkg::*;

    localparam logic [ACC_W-1:0] MOD50 = ACC_W'(FCLK_50);
    localparam logic [ACC_W-1:0] MOD10 = ACC_W'(FCLK_10);

    state_t state, next_state;

    logic [ACC_W-1:0] shadow;
    logic             bad;
    logic             last_digit;
    logic             accept;

    logic [ACC_W-1:0] sel_mod;
    logic [ACC_W-1:0] cand_mod;
    logic             reject;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] mod;
    logic [ACC_W:0]   sum;

    assign digit_ready = (state == COLLECT);
    assign accept      = digit_ready && digit_valid;

    bcd_to_bin_acc #(.NDIGITS(NDIGITS)) u_bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .clr    (state == APPLY),
        .digit  (digit_in),
        .shadow (shadow),
        .bad    (bad),
        .last   (last_digit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            COLLECT: if (last_digit) next_state = CHECK;
            CHECK:   next_state = APPLY;
            APPLY:   next_state = COLLECT;
            default: next_state = COLLECT;
        endcase
    end

    // Verdict is registered in CHECK so APPLY acts on the n10_50 seen in CHECK only
    assign sel_mod = n10_50 ? MOD50 : MOD10;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_mod <= MOD10;
            reject   <= 1'b0;
        end else if (state == CHECK) begin
            cand_mod <= sel_mod;
            reject   <= bad || (shadow > (sel_mod >> 1));
        end
    end

    // inc <= mod keeps sum < 2*mod, so a single conditional subtract suffices
    assign sum = {1'b0, acc} + {1'b0, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            inc     <= '0;
            mod     <= MOD10;
            sig_out <= 1'b0;
            active  <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (state == APPLY) err <= reject;
            if (state == APPLY && !reject) begin
                inc    <= {shadow[ACC_W-2:0], 1'b0};
                mod    <= cand_mod;
                acc    <= '0;
                active <= (shadow != '0);
                if (shadow == '0) sig_out <= 1'b0;
            end else if (active) begin
                if (sum >= {1'b0, mod}) begin
                    acc     <= ACC_W'(sum - {1'b0, mod});
                    sig_out <= ~sig_out;
                end else begin
                    acc <= ACC_W'(sum);
                end
            end else begin
                acc     <= '0;
                sig_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_freq_gen.sv
// Directed bench for freq_gen: setpoint loads, output toggle rates, error and reset behaviour.
module tb_freq_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       n10_50 = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       digit_valid = 1'b0;
    logic       digit_ready;
    logic       sig_out;
    logic       active;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    freq_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .n10_50      (n10_50),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .sig_out     (sig_out),
        .active      (active),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Feed n digits MSB first from a packed setpoint, one per cycle
    task automatic send_digits(input logic [31:0] sp, input int n);
        logic [31:0] v;
        v = sp;
        for (int i = 7; i > 7 - n; i--) begin
            digit_in    = v[i*4 +: 4];
            digit_valid = 1'b1;
            tick(1);
        end
        digit_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] sp);
        send_digits(sp, 8);
        tick(3);
    endtask

    task automatic measure(input int n, output int tog, output int rise,
                           output int gmin, output int gmax);
        logic prev;
        int   last;
        prev = sig_out; last = -1; tog = 0; rise = 0; gmin = 1 << 30; gmax = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (sig_out !== prev) begin
                tog++;
                if (sig_out) rise++;
                if (last >= 0) begin
                    if (i - last < gmin) gmin = i - last;
                    if (i - last > gmax) gmax = i - last;
                end
                last = i;
            end
            prev = sig_out;
        end
    endtask

    int tog, rise, gmin, gmax, badwin, totrise;
    int rdy_lo;

    initial begin
        #12;
        chk("rst_ready", digit_ready, 1);
        chk("rst_sig", sig_out, 0);
        chk("rst_active", active, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick(2);

        // 1 MHz from a 10 MHz clock: toggle every 5 clk
        n10_50 = 1'b0;
        load(32'h0100_0000);
        chk("1m_active", active, 1);
        chk("1m_err", err, 0);
        measure(50, tog, rise, gmin, gmax);
        chk("1m_toggles", tog, 10);
        chk("1m_gmin", gmin, 5);
        chk("1m_gmax", gmax, 5);

        // 3 MHz: 3 rising edges in every 10-clk window over 1000 clk
        load(32'h0300_0000);
        badwin = 0; totrise = 0;
        for (int w = 0; w < 100; w++) begin
            measure(10, tog, rise, gmin, gmax);
            if (rise != 3) badwin++;
            totrise += rise;
        end
        chk("3m_badwin", badwin, 0);
        chk("3m_rises", totrise, 300);

        // 5 MHz: toggle every clk; out-of-range setpoint leaves it running
        load(32'h0500_0000);
        measure(20, tog, rise, gmin, gmax);
        chk("5m_toggles", tog, 20);
        chk("5m_gmax", gmax, 1);
        load(32'h0500_0001);
        chk("range_err", err, 1);
        chk("range_active", active, 1);
        measure(20, tog, rise, gmin, gmax);
        chk("range_toggles", tog, 20);

        // Non-decimal digit rejected, then a zero setpoint stops the output
        load(32'h010A_0000);
        chk("bcd_err", err, 1);
        measure(20, tog, rise, gmin, gmax);
        chk("bcd_keep", tog, 20);
        load(32'h0000_0000);
        chk("zero_err", err, 0);
        chk("zero_active", active, 0);
        chk("zero_sig", sig_out, 0);
        measure(10, tog, rise, gmin, gmax);
        chk("zero_toggles", tog, 0);

        // 25 MHz on 50 MHz clock; digit_valid stays high with garbage through CHECK/APPLY
        n10_50 = 1'b1;
        send_digits(32'h2500_0000, 8);
        digit_valid = 1'b1;
        digit_in = 4'hF;
        rdy_lo = 0;
        for (int i = 0; i < 4 && !digit_ready; i++) begin
            rdy_lo++;
            tick(1);
        end
        digit_valid = 1'b0;
        chk("ready_low", rdy_lo, 2);
        n10_50 = 1'b0;
        tick(1);
        chk("25m_err", err, 0);
        chk("25m_active", active, 1);
        measure(20, tog, rise, gmin, gmax);
        chk("25m_toggles", tog, 20);

        // Garbage offered outside COLLECT must not have been buffered: clean load is accepted
        load(32'h0100_0000);
        chk("nobuf_err", err, 0);
        measure(50, tog, rise, gmin, gmax);
        chk("nobuf_toggles", tog, 10);

        // Reset mid-collection while running at 1 MHz
        send_digits(32'h0700_0000, 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sig", sig_out, 0);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_ready", digit_ready, 1);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        load(32'h0300_0000);
        chk("post_rst_active", active, 1);
        measure(100, tog, rise, gmin, gmax);
        chk("post_rst_rises", rise, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/freq_gen.md
FREQ_GEN -- requirements
Module: freq_gen

Interface
REQ-001 SHALL have parameter NDIGITS, default 8: BCD digits per setpoint.
REQ-002 SHALL have parameter FCLK_50, default 50_000_000: clk frequency in Hz when n10_50=1.
REQ-003 SHALL have parameter FCLK_10, default 10_000_000: clk frequency in Hz when n10_50=0.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port n10_50, input, 1 bit: clock select; 1 selects the 50 MHz modulus, 0 selects the 10 MHz modulus.
REQ-007 SHALL have port digit_in, input, 4 bits: setpoint BCD digit, most significant first.
REQ-008 SHALL have port digit_valid, input, 1 bit: digit_in is valid.
REQ-009 SHALL have port digit_ready, output, 1 bit: block accepts a digit this cycle.
REQ-010 SHALL have port sig_out, output, 1 bit: generated square wave, intended as the frequency meter's signal input.
REQ-011 SHALL have port active, output, 1 bit: generator running with a nonzero setpoint.
REQ-012 SHALL have port err, output, 1 bit: last completed setpoint was rejected.

Function
REQ-013 SHALL implement FSM states COLLECT, CHECK and APPLY; reset state is COLLECT.
REQ-014 SHALL drive digit_ready=1 only in COLLECT; a digit is accepted on a clk edge where digit_valid and digit_ready are both 1.
REQ-015 SHALL update on each accepted digit: shadow = shadow*10 + digit_in (27-bit binary), digit count +1, and bad flag |= (digit_in > 9).
REQ-016 SHALL, on the NDIGITS-th accepted digit, go COLLECT->CHECK; CHECK->APPLY and APPLY->COLLECT each take one cycle, so digit_ready is low for exactly 2 cycles.
REQ-017 SHALL, in CHECK, sample n10_50 to select mod = FCLK_50 or FCLK_10, and reject the setpoint if the bad flag is set or shadow > mod/2.
REQ-018 SHALL, in APPLY for a rejected setpoint: set err=1, keep the running setpoint, keep the modulus and keep the accumulator untouched.
REQ-019 SHALL, in APPLY for an accepted setpoint: set err=0, inc = 2*shadow, latch mod, acc = 0, leave sig_out level unchanged, and set active = (shadow != 0).
REQ-020 SHALL clear shadow, digit count and the bad flag in APPLY.
REQ-021 SHALL, every cycle with active=1, compute sum = acc + inc; if sum >= mod then acc = sum - mod and sig_out toggles, else acc = sum.
REQ-022 SHALL keep acc < mod at all times; inc <= mod guarantees that one subtraction per cycle is enough.
REQ-023 SHALL, when active=0, hold acc at 0 and force sig_out to 0.
REQ-024 SHALL produce a sig_out whose long-run frequency equals the setpoint in Hz exactly, with edge jitter of at most 1 clk.
REQ-025 SHALL ignore n10_50 changes outside CHECK.
REQ-026 SHALL ignore digit_valid outside COLLECT, with no buffering.
REQ-027 SHALL let the output keep running on the old setting while a new setpoint is being collected.

Reset
REQ-028 SHALL, while rst_n=0, set: state=COLLECT, shadow=0, count=0, bad=0, inc=0, mod=FCLK_10, acc=0, sig_out=0, active=0, err=0, digit_ready=1 (combinational from state).
REQ-029 SHALL discard a partially collected setpoint on reset; collection restarts from the first digit after reset release.

Structure
REQ-030 SHALL place FCLK_10, FCLK_50, NDIGITS, the accumulator width (27) and the FSM state encoding in shared package freq_pkg.
REQ-031 SHALL implement the digit collection (shadow, count, bad flag, multiply-by-10 done as shift-add) in sub-module bcd_to_bin_acc; the FSM and accumulator live in freq_gen.

Verification
REQ-032 SHALL cover: n10_50=0, digits 0,1,0,0,0,0,0,0 (1_000_000 Hz) -> sig_out toggles every 5 clk (period 10 clk), active=1, err=0.
REQ-033 SHALL cover: n10_50=0, setpoint 03000000 -> exactly 3 rising edges of sig_out per 10 clk, sustained over 1000 clk.
REQ-034 SHALL cover: n10_50=0, setpoint 05000000 -> sig_out toggles every clk; then setpoint 05000001 -> err=1 and the 5 MHz output continues unchanged.
REQ-035 SHALL cover: setpoint containing digit 0xA -> err=1 and the previous setting is retained; a following valid setpoint 00000000 -> err=0, active=0, sig_out=0.
REQ-036 SHALL cover: n10_50=1, setpoint 25000000 -> toggle every clk; with digit_valid held high, digit_ready is low exactly 2 cycles after the 8th digit.
REQ-037 SHALL cover: rst_n asserted after 4 of 8 digits while running at 1 MHz -> all outputs at reset values immediately, and the next 8 digits form a complete new setpoint.
